// File: rtl/quad_decoder.sv
// quad_decoder: quadrature encoder front-end for the 8-bit up/down counter.
// Synchronises and glitch-filters A/B (and optionally IDX), decodes x4 Gray
// steps into a one-cycle count_en pulse plus an up_down direction level, and
// flags illegal double-bit transitions on a sticky err output.
// Optional index path (load/load_val on filtered IDX rising edge) is built
// only when the macro QDEC_INDEX_EN is defined.

module quad_decoder #(
  parameter int FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       enc_idx,
  input  logic [7:0] preset,
  input  logic       err_clr,
  output logic       count_en,
  output logic       up_down,
  output logic       load,
  output logic [7:0] load_val,
  output logic       err
);

`ifdef QDEC_INDEX_EN
  localparam int NCH = 3;
`else
  localparam int NCH = 2;
`endif

  // Filter counter value on which the next mismatching sample commits the level.
  localparam logic [3:0] CNT_LAST  = 4'(FILT_LEN - 1);
  // Stable-cycle count after which INIT latches the current {A,B}.
  localparam logic [4:0] INIT_LAST = 5'(FILT_LEN + 1);

  typedef enum logic {
    INIT,
    TRACK
  } state_t;

  // Channel bit order: 0 = A, 1 = B, 2 = IDX (when present).
  logic [NCH-1:0]      raw_in;
  logic [NCH-1:0]      sync1;
  logic [NCH-1:0]      sync2;
  logic [NCH-1:0]      filt_lvl;
  logic [NCH-1:0][3:0] filt_cnt;

  state_t     state;
  state_t     state_next;
  logic [4:0] stable_cnt;
  logic [4:0] stable_next;
  logic [1:0] prev_ab;
  logic [1:0] prev_next;
  logic [1:0] cur_ab;
  logic       ab_stable;
  logic       step;
  logic       step_up;
  logic       illegal;
  logic       suppress;
  logic       count_en_next;
  logic       up_down_next;
  logic       err_next;

`ifdef QDEC_INDEX_EN
  assign raw_in = {enc_idx, enc_b, enc_a};
`else
  assign raw_in = {enc_b, enc_a};
  logic idx_unused;
  assign idx_unused = ^{enc_idx, preset};
`endif

  // {A,B} with A as the most significant bit, matching the Gray sequence notation.
  assign cur_ab    = {filt_lvl[0], filt_lvl[1]};
  assign ab_stable = (sync2[1:0] == filt_lvl[1:0]) &&
                     (filt_cnt[0] == 4'd0) && (filt_cnt[1] == 4'd0);

  // Two-flop synchroniser per encoder line.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  // Per-channel persistence filter: level changes only after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      filt_lvl <= '0;
      filt_cnt <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (sync2[i] == filt_lvl[i]) begin
          filt_cnt[i] <= 4'd0;
        end else if (filt_cnt[i] == CNT_LAST) begin
          filt_lvl[i] <= sync2[i];
          filt_cnt[i] <= 4'd0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + 4'd1;
        end
      end
    end
  end

`ifdef QDEC_INDEX_EN
  logic       idx_prev;
  logic       load_next;
  logic [7:0] load_val_next;

  assign load_next     = filt_lvl[2] & ~idx_prev;
  assign load_val_next = load_next ? preset : load_val;
  assign suppress      = load_next;

  // Index edge detector: load pulses one cycle after filtered IDX rises, capturing preset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_prev <= 1'b0;
      load     <= 1'b0;
      load_val <= 8'h00;
    end else begin
      idx_prev <= filt_lvl[2];
      load     <= load_next;
      load_val <= load_val_next;
    end
  end
`else
  assign suppress = 1'b0;
  assign load     = 1'b0;
  assign load_val = 8'h00;
`endif

  // Next-state and output decode: INIT waits for settled inputs, TRACK classifies each {A,B} change.
  always_comb begin
    state_next  = state;
    stable_next = stable_cnt;
    prev_next   = prev_ab;
    step        = 1'b0;
    step_up     = 1'b0;
    illegal     = 1'b0;
    unique case (state)
      INIT: begin
        if (!ab_stable) begin
          stable_next = 5'd0;
        end else if (stable_cnt == INIT_LAST) begin
          state_next  = TRACK;
          prev_next   = cur_ab;
          stable_next = 5'd0;
        end else begin
          stable_next = stable_cnt + 5'd1;
        end
      end
      TRACK: begin
        prev_next = cur_ab;
        case ({prev_ab, cur_ab})
          4'b0010, 4'b1011, 4'b1101, 4'b0100: begin
            step    = 1'b1;
            step_up = 1'b1;
          end
          4'b1000, 4'b1110, 4'b0111, 4'b0001: begin
            step    = 1'b1;
            step_up = 1'b0;
          end
          4'b0011, 4'b1100, 4'b1001, 4'b0110: begin
            illegal = 1'b1;
          end
          default: begin
          end
        endcase
      end
      default: begin
        state_next = INIT;
      end
    endcase
    count_en_next = step & ~suppress;
    up_down_next  = step ? step_up : up_down;
    err_next      = illegal ? 1'b1 : (err_clr ? 1'b0 : err);
  end

  // Decoder state and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= INIT;
      stable_cnt <= 5'd0;
      prev_ab    <= 2'b00;
      count_en   <= 1'b0;
      up_down    <= 1'b1;
      err        <= 1'b0;
    end else begin
      state      <= state_next;
      stable_cnt <= stable_next;
      prev_ab    <= prev_next;
      count_en   <= count_en_next;
      up_down    <= up_down_next;
      err        <= err_next;
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: self-checking bench for quad_decoder.
// A history-window reference model predicts every output each cycle; directed
// sequences add literal expectations. Index behaviour follows QDEC_INDEX_EN.

module tb_quad_decoder;

  localparam int FILT_LEN = 3;
  localparam int SETTLE   = FILT_LEN + 17;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       enc_a   = 1'b0;
  logic       enc_b   = 1'b0;
  logic       enc_idx = 1'b0;
  logic [7:0] preset  = 8'h00;
  logic       err_clr = 1'b0;
  logic       count_en;
  logic       up_down;
  logic       load;
  logic [7:0] load_val;
  logic       err;

  int checks_total  = 0;
  int checks_passed = 0;
  bit chk_on        = 1'b0;

  // Reference model state
  logic [2:0]  m_dly0;
  logic [2:0]  m_dly1;
  logic [2:0]  m_filt;
  logic [15:0] m_win [3];
  int          m_fill [3];
  int          m_init_left;
  logic [1:0]  m_prev;
  logic        m_idx_prev;
  logic        exp_ce;
  logic        exp_ud;
  logic        exp_load;
  logic [7:0]  exp_lv;
  logic        exp_err;

  // Directed-test statistics
  int ce_pulses;
  int ld_pulses;
  int first_ce;
  int edge_no;
  bit err_seen;

  quad_decoder #(.FILT_LEN(FILT_LEN)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enc_a    (enc_a),
    .enc_b    (enc_b),
    .enc_idx  (enc_idx),
    .preset   (preset),
    .err_clr  (err_clr),
    .count_en (count_en),
    .up_down  (up_down),
    .load     (load),
    .load_val (load_val),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks_total++;
    if (actual == expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Position of an {A,B} code along the up-counting Gray cycle.
  function automatic int gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs the DUT sampled on it.
  task automatic model_step();
    logic [2:0]  raw;
    logic [1:0]  cur_ab;
    logic [15:0] mask;
    logic        v;
    logic        step;
    logic        illegal;
    int          diff;
    raw  = {enc_idx, enc_b, enc_a};
    mask = 16'((1 << FILT_LEN) - 1);
    if (!reset_n) begin
      m_dly0 = '0;
      m_dly1 = '0;
      m_filt = '0;
      for (int c = 0; c < 3; c++) begin
        m_win[c]  = '0;
        m_fill[c] = 0;
      end
      m_init_left = SETTLE;
      m_prev      = 2'b00;
      m_idx_prev  = 1'b0;
      exp_ce      = 1'b0;
      exp_ud      = 1'b1;
      exp_load    = 1'b0;
      exp_lv      = 8'h00;
      exp_err     = 1'b0;
    end else begin
      cur_ab  = {m_filt[0], m_filt[1]};
      step    = 1'b0;
      illegal = 1'b0;
      if (m_init_left == 0) begin
        diff    = (gray_pos(cur_ab) - gray_pos(m_prev) + 4) % 4;
        step    = (diff == 1) || (diff == 3);
        illegal = (diff == 2);
        if (step) exp_ud = (diff == 1);
        m_prev = cur_ab;
      end
`ifdef QDEC_INDEX_EN
      exp_load = m_filt[2] && !m_idx_prev;
      if (exp_load) exp_lv = preset;
`else
      exp_load = 1'b0;
      exp_lv   = 8'h00;
`endif
      m_idx_prev = m_filt[2];
      exp_ce = step && !exp_load;
      if (illegal) exp_err = 1'b1;
      else if (err_clr) exp_err = 1'b0;
      for (int c = 0; c < 3; c++) begin
        v         = m_dly1[c];
        m_dly1[c] = m_dly0[c];
        m_dly0[c] = raw[c];
        m_win[c]  = {m_win[c][14:0], v};
        if (m_fill[c] < 16) m_fill[c]++;
        if (m_fill[c] >= FILT_LEN && (m_win[c] & mask) == (m_filt[c] ? 16'h0000 : mask))
          m_filt[c] = v;
      end
      if (m_init_left > 0) begin
        m_init_left--;
        if (m_init_left == 0) m_prev = {m_filt[0], m_filt[1]};
      end
    end
  endtask

  // Every cycle, compare all DUT outputs with the model's prediction.
  always @(negedge clk) begin
    if (chk_on) begin
      checkOutput("count_en", count_en, exp_ce);
      checkOutput("up_down", up_down, exp_ud);
      checkOutput("load", load, exp_load);
      checkOutput("load_val", load_val, exp_lv);
      checkOutput("err", err, exp_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (count_en) begin
      ce_pulses++;
      if (first_ce < 0) first_ce = edge_no;
    end
    if (load) ld_pulses++;
    if (err) err_seen = 1'b1;
    edge_no++;
  endtask

  task automatic clearStats();
    ce_pulses = 0;
    ld_pulses = 0;
    first_ce  = -1;
    edge_no   = 0;
    err_seen  = 1'b0;
  endtask

  task automatic applyStimulus(input logic a, input logic b, input logic idx, input int n);
    enc_a   = a;
    enc_b   = b;
    enc_idx = idx;
    repeat (n) tick();
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (SETTLE) tick();
  endtask

  logic [1:0] ab_of_pos [4];
  int         cur_pos;
  logic       idx_lvl;
  logic [1:0] ab;
  int         r;

  initial begin
    ab_of_pos[0] = 2'b00;
    ab_of_pos[1] = 2'b10;
    ab_of_pos[2] = 2'b11;
    ab_of_pos[3] = 2'b01;
    clearStats();

    // Reset with all lines low
    reset_n = 1'b0;
    tick();
    chk_on = 1'b1;
    checkOutput("rst_count_en", count_en, 0);
    checkOutput("rst_up_down", up_down, 1);
    checkOutput("rst_load", load, 0);
    checkOutput("rst_load_val", load_val, 0);
    checkOutput("rst_err", err, 0);
    reset_n = 1'b1;
    repeat (SETTLE) tick();

    // Up steps
    clearStats();
    applyStimulus(1'b1, 1'b0, 1'b0, 8);
    applyStimulus(1'b1, 1'b1, 1'b0, 8);
    applyStimulus(1'b0, 1'b1, 1'b0, 8);
    applyStimulus(1'b0, 1'b0, 1'b0, 8);
    checkOutput("up_pulses", ce_pulses, 4);
    checkOutput("up_first_latency", first_ce, FILT_LEN + 2);
    checkOutput("up_dir", up_down, 1);
    checkOutput("up_err_seen", err_seen, 0);

    // Reversal
    clearStats();
    applyStimulus(1'b0, 1'b1, 1'b0, 8);
    applyStimulus(1'b1, 1'b1, 1'b0, 8);
    applyStimulus(1'b1, 1'b0, 1'b0, 8);
    checkOutput("down_pulses", ce_pulses, 3);
    checkOutput("down_dir", up_down, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8);
    checkOutput("down_dir_hold", up_down, 0);

    // Glitch rejection on A
    clearStats();
    applyStimulus(1'b1, 1'b0, 1'b0, FILT_LEN - 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 12);
    checkOutput("glitch_pulses", ce_pulses, 0);
    checkOutput("glitch_err_seen", err_seen, 0);

    // Illegal transition 00 -> 11
    clearStats();
    applyStimulus(1'b1, 1'b1, 1'b0, 10);
    checkOutput("illegal_pulses", ce_pulses, 0);
    checkOutput("illegal_err", err, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 5);
    checkOutput("illegal_err_sticky", err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("err_cleared", err, 0);

    // Back to 00 with down steps so up_down is 0 before the index test
    applyStimulus(1'b1, 1'b0, 1'b0, 8);
    applyStimulus(1'b0, 1'b0, 1'b0, 8);
    checkOutput("pre_index_dir", up_down, 0);

    // Index edge together with an up step
    preset = 8'hA5;
    clearStats();
    applyStimulus(1'b1, 1'b0, 1'b1, 8);
`ifdef QDEC_INDEX_EN
    checkOutput("idx_load_pulses", ld_pulses, 1);
    checkOutput("idx_load_val", load_val, 8'hA5);
    checkOutput("idx_count_pulses", ce_pulses, 0);
`else
    checkOutput("idx_load_pulses", ld_pulses, 0);
    checkOutput("idx_load_val", load_val, 8'h00);
    checkOutput("idx_count_pulses", ce_pulses, 1);
`endif
    checkOutput("idx_dir", up_down, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8);

    // Set err, move to 11, then reset mid-operation
    applyStimulus(1'b0, 1'b1, 1'b0, 8);
    applyStimulus(1'b1, 1'b1, 1'b0, 8);
    checkOutput("pre_reset_err", err, 1);
    checkOutput("pre_reset_dir", up_down, 0);
    clearStats();
    reset_n = 1'b0;
    tick();
    checkOutput("midrst_count_en", count_en, 0);
    checkOutput("midrst_up_down", up_down, 1);
    checkOutput("midrst_err", err, 0);
    checkOutput("midrst_load_val", load_val, 0);
    reset_n = 1'b1;
    repeat (SETTLE) tick();
    checkOutput("midrst_pulses", ce_pulses, 0);
    checkOutput("midrst_err_seen", err_seen, 0);

    // Randomised walk: valid steps, illegal jumps, glitches, index, err_clr, resets
    cur_pos = 2;
    idx_lvl = 1'b0;
    for (int it = 0; it < 500; it++) begin
      r       = $urandom_range(0, 99);
      err_clr = ($urandom_range(0, 9) == 0);
      preset  = 8'($urandom);
      if (r < 2) begin
        doReset();
      end else if (r < 15) begin
        ab = ab_of_pos[cur_pos];
        if ($urandom_range(0, 1) == 0) ab[1] = ~ab[1];
        else ab[0] = ~ab[0];
        applyStimulus(ab[1], ab[0], idx_lvl, $urandom_range(1, 2));
        ab = ab_of_pos[cur_pos];
        applyStimulus(ab[1], ab[0], idx_lvl, $urandom_range(1, 6));
      end else begin
        if (r < 25) cur_pos = (cur_pos + 2) % 4;
        else if (r < 60) cur_pos = (cur_pos + 1) % 4;
        else cur_pos = (cur_pos + 3) % 4;
        if ($urandom_range(0, 5) == 0) idx_lvl = ~idx_lvl;
        ab = ab_of_pos[cur_pos];
        applyStimulus(ab[1], ab[0], idx_lvl, $urandom_range(1, 10));
      end
    end
    err_clr = 1'b0;
    repeat (10) tick();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
